// File: rtl/isa_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : isa_cmd_pkg
// Purpose  : Shared definitions for the ISA command register bank: Avalon
//            word offsets, CONTROL/STATUS bit positions and the command FSM
//            state type.
// Revision : 1.0 - initial release
// ============================================================================
package isa_cmd_pkg;

    // Avalon word offsets
    localparam logic [2:0] REG_ADDR    = 3'd0;
    localparam logic [2:0] REG_DATA    = 3'd1;
    localparam logic [2:0] REG_CONTROL = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_TIMEOUT = 3'd4;
    localparam logic [2:0] REG_ID      = 3'd5;

    // CONTROL bit positions
    localparam int CTRL_GO     = 0;
    localparam int CTRL_DIR    = 1;
    localparam int CTRL_IO     = 2;
    localparam int CTRL_IRQ_EN = 3;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;
    localparam int STAT_IRQ  = 3;

    // Command FSM
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } cmd_state_t;

endpackage : isa_cmd_pkg
`default_nettype wire

// File: rtl/isa_cmd_regfile_register.sv
`default_nettype none
// ============================================================================
// Module   : isa_cmd_regfile_register
// Purpose  : Generic loadable register with asynchronous active-low reset.
// Ports    : clk   - clock
//            reset - asynchronous active-low reset, loads RST_VAL
//            load  - when high, q takes d at the next rising edge
//            d     - data in   [WIDTH-1:0]
//            q     - data out  [WIDTH-1:0]
// Revision : 1.0 - initial release
// ============================================================================
module isa_cmd_regfile_register #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : isa_cmd_regfile_register
`default_nettype wire

// File: rtl/isa_cmd_regfile.sv
`default_nettype none
// ============================================================================
// Module   : isa_cmd_regfile
// Purpose  : Avalon-MM slave register bank for the CT2960 riser host
//            interface. Holds ISA address, data and control, launches one
//            ISA command per GO write over a req/ack handshake, captures read
//            data, detects timeouts and raises a maskable level interrupt.
// Ports    : clk, reset (async, active-low)
//            address/write/read/writedata/byteenable -> Avalon slave inputs
//            readdata/readdatavalid                  -> Avalon read return
//            control_reset  - synchronous soft clear of CONTROL/STATUS/FSM
//            address_out, data_out, control_out      -> register contents
//            cmd_req / cmd_ack / cmd_rdata           -> ISA cycle engine
//            irq            - level interrupt
// Revision : 1.0 - initial release
// ============================================================================
module isa_cmd_regfile
    import isa_cmd_pkg::*;
#(
    parameter int           ADDR_W      = 20,
    parameter int           DATA_W      = 16,
    parameter logic [15:0]  TIMEOUT_RST = 16'd255,
    parameter logic [31:0]  BLOCK_ID    = 32'h2960_0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              write,
    input  logic              read,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid,
    input  logic              control_reset,
    output logic [ADDR_W-1:0] address_out,
    output logic [DATA_W-1:0] data_out,
    output logic [7:0]        control_out,
    output logic              cmd_req,
    input  logic              cmd_ack,
    input  logic [DATA_W-1:0] cmd_rdata,
    output logic              irq
);

    localparam int ADDR_LANES = (ADDR_W + 7) / 8;
    localparam int DATA_LANES = (DATA_W + 7) / 8;

    cmd_state_t        state_q;
    cmd_state_t        state_d;
    logic              busy;
    logic              wr_ok;
    logic              wr_addr;
    logic              wr_data;
    logic              wr_ctrl;
    logic              wr_tmo;
    logic              w1c;
    logic              go;
    logic              ack_hit;
    logic              expire;
    logic [7:0]        ctrl_d;
    logic              ctrl_load;
    logic [7:0]        ctrl_q;
    logic [15:0]       timeout_q;
    logic [15:0]       cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              done_q;
    logic              err_q;
    logic              irq_q;
    logic [31:0]       rd_mux;

    // Register bank writes are frozen while a command is in flight and
    // whenever the soft clear is asserted.
    assign busy    = (state_q == REQ);
    assign wr_ok   = write & ~busy & ~control_reset;
    assign wr_addr = wr_ok & (address == REG_ADDR);
    assign wr_data = wr_ok & (address == REG_DATA);
    assign wr_ctrl = wr_ok & (address == REG_CONTROL);
    assign wr_tmo  = wr_ok & (address == REG_TIMEOUT);
    assign w1c     = write & (address == REG_STATUS) & byteenable[0];

    assign go      = wr_ctrl & byteenable[0] & writedata[CTRL_GO];
    assign ack_hit = busy & cmd_ack;
    // Ack has priority over expiry in the same cycle.
    assign expire  = busy & ~cmd_ack & (timeout_q != 16'd0) &
                     (cnt_q == (timeout_q - 16'd1));

    // ------------------------------------------------------------------
    // Byte-lane registers
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < ADDR_LANES; gi++) begin : g_addr_lane
        localparam int LO = 8 * gi;
        localparam int W  = ((ADDR_W - LO) > 8) ? 8 : (ADDR_W - LO);
        isa_cmd_regfile_register #(.WIDTH(W), .RST_VAL('0)) u_reg (
            .clk   (clk),
            .reset (reset),
            .load  (wr_addr & byteenable[gi]),
            .d     (writedata[LO +: W]),
            .q     (address_out[LO +: W])
        );
    end

    for (genvar gi = 0; gi < DATA_LANES; gi++) begin : g_data_lane
        localparam int LO = 8 * gi;
        localparam int W  = ((DATA_W - LO) > 8) ? 8 : (DATA_W - LO);
        isa_cmd_regfile_register #(.WIDTH(W), .RST_VAL('0)) u_reg (
            .clk   (clk),
            .reset (reset),
            .load  (wr_data & byteenable[gi]),
            .d     (writedata[LO +: W]),
            .q     (data_out[LO +: W])
        );
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_tmo_lane
        isa_cmd_regfile_register #(.WIDTH(8), .RST_VAL(TIMEOUT_RST[8*gi +: 8])) u_reg (
            .clk   (clk),
            .reset (reset),
            .load  (wr_tmo & byteenable[gi]),
            .d     (writedata[8*gi +: 8]),
            .q     (timeout_q[8*gi +: 8])
        );
    end

    // GO is a strobe and is never stored; the soft clear reuses the load
    // path with zero data so CONTROL stays a plain register.
    assign ctrl_d    = control_reset ? 8'h00 : {writedata[7:1], 1'b0};
    assign ctrl_load = control_reset | (wr_ctrl & byteenable[0]);

    isa_cmd_regfile_register #(.WIDTH(8), .RST_VAL(8'h00)) u_ctrl_reg (
        .clk   (clk),
        .reset (reset),
        .load  (ctrl_load),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    assign control_out = ctrl_q;
    assign cmd_req     = busy;
    assign irq         = irq_q;

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = REQ;
            REQ:     if (ack_hit | expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (control_reset) begin
            state_d = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Status, timeout counter, read-data capture and interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 16'd0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else if (control_reset) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            irq_q <= ctrl_q[CTRL_IRQ_EN] & (done_q | err_q);

            if (go) begin
                cnt_q <= 16'd0;
            end else if (busy) begin
                cnt_q <= cnt_q + 16'd1;
            end

            // Set beats W1C; GO clears both flags for the new command.
            if (ack_hit) begin
                done_q <= 1'b1;
            end else if (go || (w1c && writedata[STAT_DONE])) begin
                done_q <= 1'b0;
            end

            if (expire) begin
                err_q <= 1'b1;
            end else if (go || (w1c && writedata[STAT_ERR])) begin
                err_q <= 1'b0;
            end

            if (ack_hit && !ctrl_q[CTRL_DIR]) begin
                rdata_q <= cmd_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux and registered read return (latency 1)
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = 32'd0;
        case (address)
            REG_ADDR:    rd_mux = 32'(address_out);
            REG_DATA:    rd_mux = 32'(rdata_q);
            REG_CONTROL: rd_mux = {24'd0, ctrl_q};
            REG_STATUS:  rd_mux = {28'd0, irq_q, err_q, done_q, busy};
            REG_TIMEOUT: rd_mux = {16'd0, timeout_q};
            REG_ID:      rd_mux = BLOCK_ID;
            default:     rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata      <= 32'd0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            readdata      <= read ? rd_mux : 32'd0;
        end
    end

    // Upper write-data bits and lane enables beyond the register widths
    // are intentionally dropped.
    logic unused_bits;
    assign unused_bits = &{1'b0, writedata, byteenable};

endmodule : isa_cmd_regfile
`default_nettype wire

// File: doc/isa_cmd_regfile.md
Name: isa_cmd_regfile

Overview:
Parametrised Avalon-MM slave register bank for the CT2960 riser host interface. It holds the ISA target address, the data word and the control byte, and adds status, timeout and ID registers. It launches one ISA bus command per GO write over a req/ack handshake to the downstream ISA cycle engine, captures read data, and raises a maskable interrupt on completion or timeout.

Parameters:
ADDR_W, 20, width of the ISA address register and address_out (1..32)
DATA_W, 16, width of the data register, data_out and cmd_rdata (8 or 16)
TIMEOUT_RST, 16'd255, reset value of the TIMEOUT register
BLOCK_ID, 32'h2960_0001, constant returned by the ID register

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
address  in  3  Avalon word address
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
writedata  in  32  Avalon write data
byteenable  in  4  Avalon byte lanes
readdata  out  32  Avalon read data
readdatavalid  out  1  read data qualifier
control_reset  in  1  synchronous soft clear of CONTROL, STATUS and the FSM
address_out  out  ADDR_W  ISA address register
data_out  out  DATA_W  ISA write-data register
control_out  out  8  CONTROL register
cmd_req  out  1  command request to the ISA cycle engine
cmd_ack  in  1  one-cycle completion pulse from the engine
cmd_rdata  in  DATA_W  engine read data, valid with cmd_ack
irq  out  1  interrupt request, level

Behaviour:
- Register map (word address):
  - 0 ADDR: R/W [ADDR_W-1:0].
  - 1 DATA: write loads data_out; read returns RDATA, the last captured cmd_rdata.
  - 2 CONTROL: R/W [7:0]. bit0 GO (self-clearing, reads 0), bit1 DIR (1 = ISA write), bit2 IO (1 = I/O, 0 = memory), bit3 IRQ_EN, bits 7:4 R/W spare.
  - 3 STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 ERR (W1C), bit3 IRQ (RO).
  - 4 TIMEOUT: R/W [15:0].
  - 5 ID: RO BLOCK_ID.
  - 6 and 7: read 0, writes ignored.
  - Unused upper bits read 0.
- Byte enables apply per lane on ADDR, DATA, CONTROL and TIMEOUT. The STATUS W1C action uses lane 0 only.
- Reset values: ADDR=0, DATA=0, RDATA=0, CONTROL=0, STATUS=0, TIMEOUT=TIMEOUT_RST, readdata=0, readdatavalid=0, cmd_req=0, irq=0. FSM resets to IDLE.
- Read latency is fixed at 1: a read sampled at edge t gives readdata and readdatavalid=1 after edge t+1, for one cycle. readdatavalid=0 otherwise. Read data is the pre-write value when read and write to the same register coincide.
- FSM IDLE -> REQ:
  - Trigger: write to CONTROL with byteenable[0]=1 and writedata[0]=1 while IDLE.
  - CONTROL bits 7:1 update in the same write.
  - DONE and ERR clear; the timeout counter clears.
  - cmd_req=1 and BUSY=1 from the next cycle.
- FSM REQ -> IDLE on cmd_ack=1:
  - cmd_req=0 next cycle; DONE=1.
  - If DIR=0, RDATA captures cmd_rdata.
- FSM REQ -> IDLE on timeout:
  - The counter increments each REQ cycle. With TIMEOUT != 0 and no ack, count reaching TIMEOUT-1 sets ERR; cmd_req=0 next cycle.
  - TIMEOUT=0 disables the timeout.
  - cmd_ack and expiry in the same cycle: ack wins (DONE, no ERR).
- While BUSY, writes to ADDR, DATA, CONTROL and TIMEOUT are ignored (GO included). STATUS W1C is still honoured.
- DONE/ERR set and W1C in the same cycle: set wins.
- irq = CONTROL.IRQ_EN & (DONE | ERR), registered (one-cycle lag). STATUS.IRQ mirrors irq.
- control_reset=1: next edge clears CONTROL and STATUS and forces IDLE with cmd_req=0. A late cmd_ack is then ignored. ADDR, DATA, RDATA and TIMEOUT are kept. control_reset beats a simultaneous write.
- Asynchronous reset mid-command drops cmd_req immediately.
- ADDR/DATA writes wider than ADDR_W/DATA_W are truncated.

Decomposition:
- Package isa_cmd_pkg: register offsets (REG_ADDR..REG_ID), CONTROL/STATUS bit indices, FSM state enum {IDLE, REQ}.
- One natural sub-module: the existing generic Register (D, clk, reset, load, Q), parametrised by width. It is instantiated for ADDR, DATA, CONTROL and TIMEOUT, with load derived per byte lane.
- FSM, timeout counter and read mux stay in the top level.

Test Plan:
- Reset: reset low -> all outputs 0; TIMEOUT reads 0x00FF; ID reads 0x29600001; readdatavalid=0.
- Write-data command:
  - Stimulus: ADDR=0x00220 (I/O), DATA=0x00A5, then CONTROL=0x07.
  - Response: cmd_req rises one cycle later, address_out=0x00220, data_out=0x00A5, control_out=0x06.
  - ack after 5 cycles -> cmd_req falls next cycle, STATUS=0x02.
- Read capture with irq: IRQ_EN=1, DIR=0, GO; ack with cmd_rdata=0x5A3C -> DATA reads 0x5A3C, irq=1; W1C STATUS=0x02 -> irq=0.
- Timeout:
  - TIMEOUT=4, GO, no ack -> ERR after 4 REQ cycles, cmd_req drops, STATUS=0x04.
  - Repeat with ack arriving in the expiry cycle -> STATUS=0x02.
- Busy lock: ADDR write and second GO during REQ -> ignored; ADDR unchanged, one request only.
- Soft abort: control_reset during REQ -> cmd_req=0, CONTROL=0, STATUS=0; a later ack causes no DONE; byte-lane write ADDR with byteenable=4'b0010 changes bits 15:8 only.
